regfile_write_ctrl: RTL and testbench
=====================================

// Module: regfile_write_ctrl
// PURPOSE
//  Write-side controller for the 16x16 register file: buffers write requests from
//  the datapath in a small FIFO and issues them one per cycle on the register
//  file write port (C, Caddr, load). Also performs an on-request init sweep that
//  writes 0 to all 16 registers. Sits between writeback logic and the register file.
// PARAMETERS
//  DEPTH   4   write FIFO entries; power of 2, 2..16
//  AW      4   register address width (16 registers)
//  DW      16  data width
// PORTS
//  clk        in   1    rising-edge clock, single clock domain
//  clear_n    in   1    asynchronous active-low reset
//  wr_valid   in   1    write request valid
//  wr_ready   out  1    controller can accept a request this cycle
//  wr_addr    in   AW   destination register
//  wr_data    in   DW   write data
//  init_req   in   1    single-cycle pulse: zero all registers
//  init_busy  out  1    high while an init is pending or sweeping
//  C          out  DW   register file write data
//  Caddr      out  AW   register file write address
//  load       out  1    register file write enable
// BEHAVIOUR
//  - Reset (clear_n=0, async): FIFO empty, state IDLE, C=0, Caddr=0, load=0,
//    wr_ready=0, init_busy=0. wr_ready rises the first clk edge after release.
//  - All outputs registered. Accept = wr_valid & wr_ready at a clk edge.
//  - wr_ready = !full & (state==IDLE); derived from registered state, so no push
//    while full even if a pop occurs in the same cycle.
//  - Issue: in IDLE or FLUSH, if FIFO non-empty, pop head each cycle; next cycle
//    load=1, Caddr/C=head. Otherwise load=0 (C/Caddr hold last value).
//  - Latency: request accepted at edge N into empty FIFO -> load=1 for the cycle
//    after edge N+1; register file captures it at edge N+2. Order preserved.
//  - Simultaneous push and pop: both take effect; count unchanged.
//  - Pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits, 0..DEPTH.
//  - FSM:
//    IDLE : init_req -> FLUSH.
//    FLUSH: wr_ready=0, init_busy=1; drain FIFO; when empty and no issue
//           pending -> INIT with sweep counter=0.
//    INIT : wr_ready=0, init_busy=1; each cycle load=1, C=0, Caddr=counter,
//           counter++; after Caddr=15 issued -> IDLE (16 load cycles exactly).
//  - init_req while in FLUSH or INIT is ignored (no restart, no queueing).
//  - init_req and accepted write in the same IDLE cycle: write is enqueued and
//    is issued before the sweep (hence overwritten by it).
//  - Reset mid-operation: queued writes discarded, sweep aborted, load drops
//    to 0 immediately (async).
// CONFIGURATION
//  REGFILE_ZERO_R0_EN defined: register 0 is hard-wired zero; a request with
//    wr_addr=0 completes its handshake but is dropped (not enqueued, never
//    issued). Init sweep still covers 0..15.
//  Undefined: address 0 is an ordinary register, written like any other.
// TESTING
//  1 Reset: clear_n low mid-cycle -> load=0, wr_ready=0 at once; wr_ready=1 one
//    edge after release.
//  2 Single write addr=5 data=0xBEEF into empty FIFO -> exactly one load cycle,
//    Caddr=5, C=0xBEEF, two edges after accept; readback via register file.
//  3 Back-to-back 6 writes, DEPTH=4, wr_valid held -> wr_ready drops when full,
//    all 6 issued in order, no loss/duplication, one load per cycle.
//  4 Queue 3 writes then init_req -> init_busy=1 at once, 3 writes issued, then
//    16 load cycles Caddr 0..15 C=0; all registers read 0; init_busy falls,
//    wr_ready=1. Second init_req during sweep has no effect.
//  5 Write addr=0 data=0x1234: with REGFILE_ZERO_R0_EN no load occurs and r0
//    reads 0; without it load with Caddr=0, r0 reads 0x1234.
//  6 Reset asserted during INIT at Caddr=7 -> load=0 immediately; after release
//    state IDLE, FIFO empty, no further sweep loads.

Source files
------------

// File: rtl/regfile_write_ctrl_if.sv
// Write-request and init handshake between writeback logic and
// the register-file write controller.
//   master: wr_valid/wr_addr/wr_data/init_req out, wr_ready/init_busy in
//   slave : mirror of master
interface regfile_write_ctrl_if #(
  parameter int AW = 4,
  parameter int DW = 16
);
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          init_req;
  logic          init_busy;

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data,
    output init_req,
    input  wr_ready,
    input  init_busy
  );

  modport slave (
    input  wr_valid,
    input  wr_addr,
    input  wr_data,
    input  init_req,
    output wr_ready,
    output init_busy
  );
endinterface

// File: rtl/regfile_write_ctrl.sv
// Register-file write controller: FIFO-buffered writes issued one
// per cycle on (C, Caddr, load), plus an init sweep zeroing 0..2**AW-1.
// Ports: clk, clear_n (async active-low), wr (slave handshake:
//   wr_valid/wr_ready/wr_addr/wr_data/init_req/init_busy),
//   C/Caddr/load (register-file write port, all registered).
// Option: REGFILE_ZERO_R0_EN drops accepted writes to address 0.
module regfile_write_ctrl #(
  parameter int DEPTH = 4,
  parameter int AW    = 4,
  parameter int DW    = 16
) (
  input  logic                 clk,
  input  logic                 clear_n,
  regfile_write_ctrl_if.slave  wr,
  output logic [DW-1:0]        C,
  output logic [AW-1:0]        Caddr,
  output logic                 load
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FLUSH,
    S_INIT
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_mem [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];
  logic [PW-1:0] wptr_q;
  logic [PW-1:0] rptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] swp_q;
  logic          load_q;
  logic [DW-1:0] c_q;
  logic [AW-1:0] caddr_q;
  logic          rdy_q, rdy_d;
  logic          busy_q;

  logic accept;
  logic push;
  logic pop;
  logic swp_last;

  assign accept = wr.wr_valid & rdy_q;

`ifdef REGFILE_ZERO_R0_EN
  // r0 is hard-wired zero: handshake completes, entry discarded
  assign push = accept & (wr.wr_addr != '0);
`else
  assign push = accept;
`endif

  assign pop      = (state_q != S_INIT) & (cnt_q != '0);
  assign swp_last = (swp_q == {AW{1'b1}});

  always_comb begin
    cnt_d   = cnt_q + CW'(push) - CW'(pop);
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (wr.init_req) state_d = S_FLUSH;
      S_FLUSH: if (cnt_q == '0) state_d = S_INIT;
      S_INIT:  if (swp_last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // ready reflects next-cycle state and fill, so it never
    // admits a push into a full FIFO even with a pop pending
    rdy_d = (state_d == S_IDLE) & (cnt_d != CW'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wptr_q] <= wr.wr_addr;
      data_mem[wptr_q] <= wr.wr_data;
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= S_IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      swp_q   <= '0;
      load_q  <= 1'b0;
      c_q     <= '0;
      caddr_q <= '0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
      busy_q  <= (state_d != S_IDLE);
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      if (state_q == S_FLUSH) swp_q <= '0;
      if (pop) begin
        load_q  <= 1'b1;
        c_q     <= data_mem[rptr_q];
        caddr_q <= addr_mem[rptr_q];
      end else if (state_q == S_INIT) begin
        load_q  <= 1'b1;
        c_q     <= '0;
        caddr_q <= swp_q;
        swp_q   <= swp_q + 1'b1;
      end else begin
        load_q  <= 1'b0;
      end
    end
  end

  assign C            = c_q;
  assign Caddr        = caddr_q;
  assign load         = load_q;
  assign wr.wr_ready  = rdy_q;
  assign wr.init_busy = busy_q;

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// Scoreboard bench for regfile_write_ctrl: expected writes queued on
// handshake, popped and compared by a monitor on every load cycle.
module tb_regfile_write_ctrl;

  logic        clk;
  logic        clear_n;
  logic [15:0] C;
  logic [3:0]  Caddr;
  logic        load;

  regfile_write_ctrl_if #(.AW(4), .DW(16)) wif ();

  regfile_write_ctrl #(.DEPTH(4), .AW(4), .DW(16)) dut (
    .clk     (clk),
    .clear_n (clear_n),
    .wr      (wif.slave),
    .C       (C),
    .Caddr   (Caddr),
    .load    (load)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        sw;
    logic [3:0]  a;
    logic [15:0] d;
  } ent_t;

  ent_t        exp_q [$];
  int          sweep_left = 0;
  int          n_pass = 0;
  int          n_tot = 0;
  logic [15:0] tb_rf  [16];
  logic [15:0] ref_rf [16];

`ifdef REGFILE_ZERO_R0_EN
  localparam bit ZR0 = 1'b1;
`else
  localparam bit ZR0 = 1'b0;
`endif

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h at %0t", nm, got, exp, $time);
  endtask

  // reference: accepted request -> one future load, init -> 16 zero loads
  always @(posedge clk) begin
    if (clear_n) begin
      if (wif.wr_valid && wif.wr_ready && !(ZR0 && wif.wr_addr == 4'd0))
        exp_q.push_back('{sw: 1'b0, a: wif.wr_addr, d: wif.wr_data});
      if (wif.init_req && sweep_left == 0) begin
        for (int i = 0; i < 16; i++)
          exp_q.push_back('{sw: 1'b1, a: 4'(i), d: 16'h0});
        sweep_left = 16;
      end
    end
  end

  // register file model: captures at the edge ending a load cycle
  always @(posedge clk) begin
    if (load) tb_rf[Caddr] <= C;
  end

  always @(negedge clk) begin
    ent_t e;
    if (clear_n) begin
      if (load) begin
        if (exp_q.size() == 0) begin
          n_tot++;
          $display("FAIL unexpected_load: got addr=%0d data=%0h required no load",
                   Caddr, C);
        end else begin
          e = exp_q.pop_front();
          chk("load_addr", 32'(Caddr), 32'(e.a));
          chk("load_data", 32'(C), 32'(e.d));
          ref_rf[e.a] = e.d;
          if (e.sw) sweep_left--;
        end
      end
      chk("init_busy", 32'(wif.init_busy), 32'(sweep_left != 0));
      if (sweep_left != 0) chk("wr_ready_busy", 32'(wif.wr_ready), 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [3:0] a, logic [15:0] d);
    logic r;
    wif.wr_valid = 1'b1;
    wif.wr_addr  = a;
    wif.wr_data  = d;
    for (int g = 0; g < 50; g++) begin
      r = wif.wr_ready;
      tick();
      if (r) return;
    end
    chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse_init();
    wif.init_req = 1'b1;
    tick();
    wif.init_req = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || wif.init_busy) && g < 300) begin
      tick();
      g++;
    end
    chk("drain_timeout", 32'(g < 300), 32'd1);
    repeat (2) tick();
  endtask

  initial begin
    logic found;
    for (int i = 0; i < 16; i++) begin
      tb_rf[i]  = 16'h0;
      ref_rf[i] = 16'h0;
    end
    clear_n      = 1'b0;
    wif.wr_valid = 1'b0;
    wif.wr_addr  = '0;
    wif.wr_data  = '0;
    wif.init_req = 1'b0;

    // reset values, ready one edge after release
    #2;
    chk("rst_load", 32'(load), 32'd0);
    chk("rst_ready", 32'(wif.wr_ready), 32'd0);
    chk("rst_busy", 32'(wif.init_busy), 32'd0);
    chk("rst_caddr", 32'(Caddr), 32'd0);
    chk("rst_c", 32'(C), 32'd0);
    #10 clear_n = 1'b1;
    #1 chk("ready_before_edge", 32'(wif.wr_ready), 32'd0);
    tick();
    chk("ready_after_release", 32'(wif.wr_ready), 32'd1);

    // single write: load exactly in the cycle after edge N+1
    wif.wr_valid = 1'b1;
    wif.wr_addr  = 4'd5;
    wif.wr_data  = 16'hBEEF;
    chk("t2_ready", 32'(wif.wr_ready), 32'd1);
    tick();
    wif.wr_valid = 1'b0;
    chk("t2_load_n", 32'(load), 32'd0);
    tick();
    chk("t2_load_n1", 32'(load), 32'd1);
    chk("t2_caddr", 32'(Caddr), 32'd5);
    chk("t2_c", 32'(C), 32'hBEEF);
    tick();
    chk("t2_load_n2", 32'(load), 32'd0);
    chk("t2_rf5", 32'(tb_rf[5]), 32'hBEEF);
    drain();

    // six writes with valid held
    for (int i = 0; i < 6; i++) send(4'(i + 8), 16'(16'hA000 + i));
    wif.wr_valid = 1'b0;
    drain();
    for (int i = 0; i < 6; i++)
      chk("t3_rf", 32'(tb_rf[i + 8]), 32'(16'hA000 + i));

    // address 0
    send(4'd0, 16'h1234);
    wif.wr_valid = 1'b0;
    drain();
    chk("t5_r0", 32'(tb_rf[0]), ZR0 ? 32'd0 : 32'h1234);

    // queued writes then init, second init mid-sweep ignored
    send(4'd1, 16'h1111);
    send(4'd2, 16'h2222);
    wif.init_req = 1'b1;
    send(4'd3, 16'h3333);
    wif.init_req = 1'b0;
    wif.wr_valid = 1'b0;
    repeat (8) tick();
    pulse_init();
    drain();
    chk("t4_ready", 32'(wif.wr_ready), 32'd1);
    chk("t4_busy", 32'(wif.init_busy), 32'd0);
    for (int i = 0; i < 16; i++) chk("t4_rf_zero", 32'(tb_rf[i]), 32'd0);

    // random traffic with occasional init
    for (int k = 0; k < 400; k++) begin
      wif.wr_valid = ($urandom_range(3) != 0);
      wif.wr_addr  = 4'($urandom_range(15));
      wif.wr_data  = 16'($urandom);
      wif.init_req = ($urandom_range(39) == 0);
      tick();
    end
    wif.wr_valid = 1'b0;
    wif.init_req = 1'b0;
    drain();
    for (int i = 0; i < 16; i++) chk("rand_rf", 32'(tb_rf[i]), 32'(ref_rf[i]));

    // reset during sweep at Caddr 7
    pulse_init();
    found = 1'b0;
    for (int g = 0; g < 100 && !found; g++) begin
      @(negedge clk);
      if (load && Caddr == 4'd7) found = 1'b1;
    end
    chk("t6_reach7", 32'(found), 32'd1);
    #1 clear_n = 1'b0;
    #1;
    chk("t6_load_async", 32'(load), 32'd0);
    chk("t6_ready_async", 32'(wif.wr_ready), 32'd0);
    chk("t6_busy_async", 32'(wif.init_busy), 32'd0);
    exp_q.delete();
    sweep_left = 0;
    repeat (2) @(posedge clk);
    #3 clear_n = 1'b1;
    tick();
    chk("t6_ready_rel", 32'(wif.wr_ready), 32'd1);
    for (int i = 0; i < 30; i++) begin
      chk("t6_no_load", 32'(load), 32'd0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
